dma_rd_tag_manager: RTL and testbench

- Owns the pool of non-posted read tags for the DMA read-request path.
- Serves the requester's tag_read_req/tag_read_ack handshake and hands out the lowest free tag.
- Reclaims tags when the completion path reports a tag's final CplD.
- Tracks outstanding reads and signals completion of a whole DMA read once its last request's tags are all returned.

---
 rtl/dma_rd_tag_manager.sv | 149 ++++++++++++++
 tb/tb_dma_rd_tag_manager.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_tag_manager.sv
// dma_rd_tag_manager
// Owns the pool of non-posted read tags for the DMA read-request path.
// Grants the lowest free tag to the read engine, reclaims tags on their final
// CplD, counts outstanding reads and pulses dma_rd_done once the final
// request of a DMA read has had all of its tags returned.
module dma_rd_tag_manager #(
  parameter int NUM_TAGS = 32,
  parameter int TAG_W    = 6,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tag_read_req,
  input  logic             tag_read_last,
  output logic             tag_read_ack,
  output logic [TAG_W-1:0] tag_read_number,
  input  logic             tag_free_valid,
  input  logic [TAG_W-1:0] tag_free_number,
  output logic [CNT_W-1:0] tags_outstanding,
  output logic             tag_pool_empty,
  output logic             dma_rd_done,
  output logic             tag_err,
  input  logic             tag_err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [NUM_TAGS-1:0] ALL_FREE = '1;
  localparam logic [NUM_TAGS-1:0] ONE_BIT  = NUM_TAGS'(1);

  state_t              r_state;
  logic [NUM_TAGS-1:0] r_free;
  logic [CNT_W-1:0]    r_outstanding;
  logic                r_last_pending;
  logic                r_ack;
  logic [TAG_W-1:0]    r_tag;
  logic                r_empty;
  logic                r_done;
  logic                r_err;

  logic [TAG_W-1:0]    w_low_tag;
  logic                w_any_free;
  logic                w_grant;
  logic [NUM_TAGS-1:0] w_grant_mask;
  logic [NUM_TAGS-1:0] w_rel_onehot;
  logic                w_rel_ok;
  logic                w_rel_bad;
  logic [NUM_TAGS-1:0] w_rel_mask;
  logic [NUM_TAGS-1:0] w_free_next;
  logic [CNT_W-1:0]    w_cnt_next;

  // Priority encoder: lowest-index free tag in the current-cycle bitmap.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    w_low_tag  = '0;
    w_any_free = |r_free;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (r_free[i]) begin
        w_low_tag = TAG_W'(i);
      end
    end
  end

  // Grant/release decode and next bitmap and counter values.
  always_comb begin
    w_grant      = (r_state == ST_IDLE) && tag_read_req && w_any_free;
    w_grant_mask = w_grant ? (ONE_BIT << w_low_tag) : '0;
    // A shift past the pool width yields zero, so out-of-range tags never
    // match an allocated bit and fall into the error path.
    w_rel_onehot = ONE_BIT << tag_free_number;
    // Legality is judged on the pre-grant bitmap: releasing the tag being
    // granted this cycle means releasing a free tag, which is an error.
    w_rel_ok     = tag_free_valid && (|(w_rel_onehot & ~r_free));
    w_rel_bad    = tag_free_valid && !w_rel_ok;
    w_rel_mask   = w_rel_ok ? w_rel_onehot : '0;
    // The released bit only reaches the encoder next cycle via r_free.
    w_free_next  = (r_free & ~w_grant_mask) | w_rel_mask;
    w_cnt_next   = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_rel_ok);
  end

  // Tag pool bookkeeping: free bitmap, outstanding count, empty flag, error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_free        <= ALL_FREE;
      r_outstanding <= '0;
      r_empty       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_free        <= w_free_next;
      r_outstanding <= w_cnt_next;
      r_empty       <= (w_free_next == '0);
      if (w_rel_bad) begin
        r_err <= 1'b1;
      end else if (tag_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Grant FSM: IDLE grants, HOLD absorbs the req drop, DRAIN waits for the last tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_last_pending <= 1'b0;
      r_ack          <= 1'b0;
      r_tag          <= '0;
      r_done         <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_ack          <= 1'b1;
            r_tag          <= w_low_tag;
            r_last_pending <= tag_read_last;
            r_state        <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_state <= r_last_pending ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (r_outstanding == '0) begin
            r_done         <= 1'b1;
            r_last_pending <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tag_read_ack     = r_ack;
  assign tag_read_number  = r_tag;
  assign tags_outstanding = r_outstanding;
  assign tag_pool_empty   = r_empty;
  assign dma_rd_done      = r_done;
  assign tag_err          = r_err;

endmodule

// File: tb/tb_dma_rd_tag_manager.sv
// Testbench for dma_rd_tag_manager: a reference model of the free bitmap
// predicts each granted tag, pushes it to a queue when the request is driven,
// and the tag is popped and compared when the DUT acknowledges.
module tb_dma_rd_tag_manager;

  localparam int NUM_TAGS = 32;
  localparam int TAG_W    = 6;
  localparam int CNT_W    = 7;
  localparam int BUDGET   = 20;

  logic             clk;
  logic             rst;
  logic             tag_read_req;
  logic             tag_read_last;
  logic             tag_read_ack;
  logic [TAG_W-1:0] tag_read_number;
  logic             tag_free_valid;
  logic [TAG_W-1:0] tag_free_number;
  logic [CNT_W-1:0] tags_outstanding;
  logic             tag_pool_empty;
  logic             dma_rd_done;
  logic             tag_err;
  logic             tag_err_clr;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit [NUM_TAGS-1:0] m_free;
  int m_cnt;
  bit m_err;
  int cyc = 0;
  int last_ack_cyc = -100;
  int done_cnt = 0;

  dma_rd_tag_manager #(
    .NUM_TAGS(NUM_TAGS),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tag_read_req    (tag_read_req),
    .tag_read_last   (tag_read_last),
    .tag_read_ack    (tag_read_ack),
    .tag_read_number (tag_read_number),
    .tag_free_valid  (tag_free_valid),
    .tag_free_number (tag_free_number),
    .tags_outstanding(tags_outstanding),
    .tag_pool_empty  (tag_pool_empty),
    .dma_rd_done     (dma_rd_done),
    .tag_err         (tag_err),
    .tag_err_clr     (tag_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (dma_rd_done === 1'b1) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int model_lowest();
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (m_free[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_free = '1;
    m_cnt  = 0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_release(input int t);
    if (t < NUM_TAGS && !m_free[t]) begin
      m_free[t] = 1'b1;
      m_cnt--;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Reserve the model's lowest free tag and queue it as the expected grant.
  task automatic model_grant();
    int g;
    g = model_lowest();
    exp_q.push_back(g);
    m_free[g] = 1'b0;
    m_cnt++;
  endtask

  // One-cycle release pulse; called and returns just after a rising edge.
  task automatic rel(input int t);
    tag_free_valid  = 1'b1;
    tag_free_number = TAG_W'(t);
    model_release(t);
    @(posedge clk); #1;
    tag_free_valid = 1'b0;
  endtask

  task automatic release_all();
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (!m_free[i]) rel(i);
    end
  endtask

  // Raise req, wait for ack within a budget, compare the granted tag against
  // the queue, then drop req the cycle after ack as the read engine does.
  task automatic issue_req(input bit last, input bit expect_grant);
    bit got;
    int exp_tag;
    if (expect_grant) model_grant();
    tag_read_req  = 1'b1;
    tag_read_last = last;
    got = 1'b0;
    for (int k = 0; k < BUDGET && !got; k++) begin
      @(posedge clk); #1;
      if (tag_read_ack === 1'b1) got = 1'b1;
    end
    checks++;
    if (expect_grant) begin
      if (!got) begin
        errors++;
        $display("FAIL grant_timeout: no ack within %0d cycles, required an ack", BUDGET);
        void'(exp_q.pop_front());
      end else begin
        exp_tag = exp_q.pop_front();
        if (tag_read_number !== TAG_W'(exp_tag)) begin
          errors++;
          $display("FAIL grant_tag: got %0d, required %0d", tag_read_number, exp_tag);
        end
        checks++;
        if (cyc - last_ack_cyc < 2) begin
          errors++;
          $display("FAIL ack_spacing: got %0d cycles, required >= 2", cyc - last_ack_cyc);
        end
        last_ack_cyc = cyc;
      end
    end else if (got) begin
      errors++;
      $display("FAIL unexpected_ack: got ack with tag %0d, required none", tag_read_number);
    end
    if (got) begin
      @(posedge clk); #1;
      checks++;
      if (tag_read_ack !== 1'b0) begin
        errors++;
        $display("FAIL ack_pulse: ack still %b one cycle later, required 0", tag_read_ack);
      end
    end
    tag_read_req  = 1'b0;
    tag_read_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tag_read_req = 0; tag_read_last = 0; tag_free_valid = 0;
    tag_free_number = '0; tag_err_clr = 0;
    model_reset();
    #20;
    checks++;
    if ({tag_read_ack, tag_read_number, tags_outstanding, tag_pool_empty, dma_rd_done, tag_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b num=%0d out=%0d empty=%b done=%b err=%b, required all 0",
               tag_read_ack, tag_read_number, tags_outstanding, tag_pool_empty, dma_rd_done, tag_err);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) issue_req(1'b0, 1'b1);
    checks++;
    if (tags_outstanding !== CNT_W'(m_cnt)) begin
      errors++;
      $display("FAIL b2b_outstanding: got %0d, required %0d", tags_outstanding, m_cnt);
    end
  endtask

  task automatic test_reuse();
    rel(1);
    issue_req(1'b0, 1'b1);
    rel(0); rel(1); rel(2);
    checks++;
    if (tags_outstanding !== CNT_W'(0) || tag_err !== 1'b0) begin
      errors++;
      $display("FAIL reuse_final: out=%0d err=%b, required out=0 err=0", tags_outstanding, tag_err);
    end
  endtask

  task automatic test_pool_full();
    int exp_tag;
    for (int i = 0; i < NUM_TAGS; i++) issue_req(1'b0, 1'b1);
    checks++;
    if (tag_pool_empty !== 1'b1 || tags_outstanding !== CNT_W'(NUM_TAGS)) begin
      errors++;
      $display("FAIL full_state: empty=%b out=%0d, required empty=1 out=%0d",
               tag_pool_empty, tags_outstanding, NUM_TAGS);
    end
    issue_req(1'b0, 1'b0);
    // Held request is served two cycles after the release of tag 17.
    tag_read_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rel(17);
    checks++;
    if (tag_read_ack !== 1'b0) begin
      errors++;
      $display("FAIL full_release_same_cycle: ack=%b, required 0", tag_read_ack);
    end
    model_grant();
    @(posedge clk); #1;
    checks++;
    exp_tag = exp_q.pop_front();
    if (tag_read_ack !== 1'b1 || tag_read_number !== TAG_W'(exp_tag)) begin
      errors++;
      $display("FAIL full_regrant: ack=%b tag=%0d, required ack=1 tag=%0d",
               tag_read_ack, tag_read_number, exp_tag);
    end
    last_ack_cyc = cyc;
    @(posedge clk); #1;
    tag_read_req = 1'b0;
    checks++;
    if (tag_pool_empty !== 1'b1) begin
      errors++;
      $display("FAIL full_empty_again: empty=%b, required 1", tag_pool_empty);
    end
    release_all();
    checks++;
    if (tag_pool_empty !== 1'b0 || tags_outstanding !== CNT_W'(0)) begin
      errors++;
      $display("FAIL full_drained: empty=%b out=%0d, required empty=0 out=0",
               tag_pool_empty, tags_outstanding);
    end
  endtask

  task automatic test_last_drain();
    int done0;
    for (int i = 0; i < 4; i++) issue_req(1'b0, 1'b1);
    issue_req(1'b1, 1'b1);
    issue_req(1'b0, 1'b0);
    done0 = done_cnt;
    for (int i = 0; i < 4; i++) rel(i);
    rel(4);
    checks++;
    if (tags_outstanding !== CNT_W'(0) || dma_rd_done !== 1'b0) begin
      errors++;
      $display("FAIL drain_zero: out=%0d done=%b, required out=0 done=0", tags_outstanding, dma_rd_done);
    end
    @(posedge clk); #1;
    checks++;
    if (dma_rd_done !== 1'b1) begin
      errors++;
      $display("FAIL drain_done: done=%b, required 1", dma_rd_done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt - done0 !== 1) begin
      errors++;
      $display("FAIL drain_done_count: got %0d pulses, required 1", done_cnt - done0);
    end
    issue_req(1'b0, 1'b1);
    release_all();
  endtask

  task automatic test_err();
    int exp_tag;
    issue_req(1'b0, 1'b1);
    rel(5);
    rel(40);
    checks++;
    if (tag_err !== m_err || tags_outstanding !== CNT_W'(m_cnt)) begin
      errors++;
      $display("FAIL err_sticky: err=%b out=%0d, required err=%b out=%0d",
               tag_err, tags_outstanding, m_err, m_cnt);
    end
    tag_err_clr = 1'b1;
    @(posedge clk); #1;
    tag_err_clr = 1'b0;
    m_err = 1'b0;
    checks++;
    if (tag_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b, required 0", tag_err);
    end
    // New error and clear in the same cycle: the error wins.
    tag_err_clr = 1'b1;
    rel(9);
    tag_err_clr = 1'b0;
    checks++;
    if (tag_err !== 1'b1) begin
      errors++;
      $display("FAIL err_beats_clear: err=%b, required 1", tag_err);
    end
    tag_err_clr = 1'b1;
    @(posedge clk); #1;
    tag_err_clr = 1'b0;
    m_err = 1'b0;
    // Grant and release in one cycle: freed tag 0 not grantable yet, tag 1 granted.
    for (int pass = 0; pass < 2; pass++) begin
      exp_tag = model_lowest();
      tag_read_req    = 1'b1;
      tag_free_valid  = 1'b1;
      tag_free_number = TAG_W'(pass == 0 ? 0 : exp_tag);
      model_release(pass == 0 ? 0 : exp_tag);
      m_free[exp_tag] = 1'b0;
      m_cnt++;
      @(posedge clk); #1;
      tag_free_valid = 1'b0;
      checks++;
      if (tag_read_ack !== 1'b1 || tag_read_number !== TAG_W'(exp_tag) ||
          tags_outstanding !== CNT_W'(m_cnt) || tag_err !== m_err) begin
        errors++;
        $display("FAIL grant_release_%0d: ack=%b tag=%0d out=%0d err=%b, required ack=1 tag=%0d out=%0d err=%b",
                 pass, tag_read_ack, tag_read_number, tags_outstanding, tag_err,
                 exp_tag, m_cnt, m_err);
      end
      last_ack_cyc = cyc;
      @(posedge clk); #1;
      tag_read_req = 1'b0;
    end
    release_all();
    tag_err_clr = 1'b1;
    @(posedge clk); #1;
    tag_err_clr = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int done0;
    for (int i = 0; i < 5; i++) issue_req(1'b0, 1'b1);
    issue_req(1'b1, 1'b1);
    checks++;
    if (tags_outstanding !== CNT_W'(6)) begin
      errors++;
      $display("FAIL pre_reset_outstanding: got %0d, required 6", tags_outstanding);
    end
    done0 = done_cnt;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (tag_read_ack !== 1'b0 || tags_outstanding !== CNT_W'(0) || tag_pool_empty !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ack=%b out=%0d empty=%b, required 0/0/0",
               tag_read_ack, tags_outstanding, tag_pool_empty);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    rel(3);
    checks++;
    if (tag_err !== 1'b1 || done_cnt !== done0) begin
      errors++;
      $display("FAIL late_release: err=%b done_pulses=%0d, required err=1 done_pulses=0",
               tag_err, done_cnt - done0);
    end
    tag_err_clr = 1'b1;
    @(posedge clk); #1;
    tag_err_clr = 1'b0;
    m_err = 1'b0;
    issue_req(1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_reuse();
    test_pool_full();
    test_last_drain();
    test_err();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
